// File: rtl/seg_scan_decoder.sv
// Recovers the digits shown on a multiplexed, active-low 4-digit 7-segment display
// by watching its scan lines, debouncing each digit before capture.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 50000
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic [3:0]  sm_wei,
    input  logic [7:0]  sm_duan,
    output logic [15:0] digits,
    output logic        frame_done,
    output logic        seg_err,
    output logic        sel_err,
    output logic        stale
);

    localparam int unsigned SAMPLE_W = 11;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] SETTLE_TGT = CNT_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_c;
    logic [SAMPLE_W-1:0] sample_q, sample_c;
    logic [TO_W-1:0]     tcnt_q;
    logic [15:0]         shadow_q, shadow_new_c;
    logic [3:0]          mask_q, mask_next_c;
    logic                multi_q;
    logic                same_c, sel_valid_c, sel_multi_c, capture_c;
    logic [1:0]          slot_c;
    logic [3:0]          code_c;
    logic                unused_dp;

    // Decimal point plays no part in the digit code.
    assign unused_dp = sm_duan[7];

    function automatic logic [3:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = 4'h0;
            7'h79:   decode = 4'h1;
            7'h24:   decode = 4'h2;
            7'h30:   decode = 4'h3;
            7'h19:   decode = 4'h4;
            7'h12:   decode = 4'h5;
            7'h02:   decode = 4'h6;
            7'h78:   decode = 4'h7;
            7'h00:   decode = 4'h8;
            7'h10:   decode = 4'h9;
            7'h7F:   decode = 4'hF;
            default: decode = 4'hE;
        endcase
    endfunction

    assign sample_c  = {sm_wei, sm_duan[6:0]};
    assign same_c    = (sample_c == sample_q);
    assign cnt_inc_c = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign code_c    = decode(sm_duan[6:0]);

    // Select classification: one low bit names the digit being driven.
    always_comb begin
        sel_valid_c = 1'b1;
        slot_c      = 2'd0;
        case (sm_wei)
            4'b1110: slot_c = 2'd0;
            4'b1101: slot_c = 2'd1;
            4'b1011: slot_c = 2'd2;
            4'b0111: slot_c = 2'd3;
            default: sel_valid_c = 1'b0;
        endcase
        sel_multi_c = !sel_valid_c && (sm_wei != 4'hF);
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stability tracking: cnt_q counts consecutive identical samples seen.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_valid_c) begin
                    state_d = SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            SETTLE: begin
                if (same_c) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c >= SETTLE_TGT) begin
                        capture_c = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (sel_valid_c) begin
                    cnt_d = 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!same_c) begin
                    if (sel_valid_c) begin
                        state_d = SETTLE;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow with the current capture merged in, so a completing frame sees it.
    always_comb begin
        shadow_new_c = shadow_q;
        for (int i = 0; i < 4; i++) begin
            if (capture_c && (slot_c == 2'(i)))
                shadow_new_c[4*i +: 4] = code_c;
        end
        mask_next_c = mask_q | ~sm_wei;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sample_q   <= '1;
            shadow_q   <= '1;
            mask_q     <= '0;
            tcnt_q     <= '0;
            multi_q    <= 1'b0;
            digits     <= 16'hFFFF;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            sel_err    <= 1'b0;
            stale      <= 1'b1;
        end else begin
            sample_q   <= sample_c;
            shadow_q   <= shadow_new_c;
            multi_q    <= sel_multi_c;
            sel_err    <= sel_multi_c && !multi_q;
            frame_done <= 1'b0;
            seg_err    <= capture_c && (code_c == 4'hE);
            if (capture_c) begin
                tcnt_q <= '0;
                stale  <= 1'b0;
                if (mask_next_c == 4'hF) begin
                    digits     <= shadow_new_c;
                    frame_done <= 1'b1;
                    mask_q     <= '0;
                end else begin
                    mask_q <= mask_next_c;
                end
            end else if (tcnt_q != TO_MAX) begin
                tcnt_q <= tcnt_q + TO_W'(1);
                if (tcnt_q == TO_LAST) begin
                    stale  <= 1'b1;
                    mask_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected frames go into a queue that a
// negedge monitor drains whenever frame_done pulses; error pulses are tallied.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TO     = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wei;
    logic [7:0]  duan;
    logic [15:0] digits;
    logic        frame_done, seg_err, sel_err, stale;

    int          tests = 0;
    int          fails = 0;
    int          seg_cnt = 0;
    int          sel_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int          s_seg, s_sel;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TO)) dut (
        .clk_50MHz (clk),
        .reset     (rst),
        .sm_wei    (wei),
        .sm_duan   (duan),
        .digits    (digits),
        .frame_done(frame_done),
        .seg_err   (seg_err),
        .sel_err   (sel_err),
        .stale     (stale)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one digit, wait n edges, return just after the last edge.
    task automatic hold(input logic [3:0] w, input logic [7:0] d, input int n);
        wei  = w;
        duan = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic [15:0] exp);
        hold(4'hE, d0, 8);
        hold(4'hD, d1, 8);
        hold(4'hB, d2, 8);
        exp_q.push_back(exp);
        hold(4'h7, d3, 8);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " digits"},     32'(digits),     32'hFFFF);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " seg_err"},    32'(seg_err),    32'd0);
        check({tag, " sel_err"},    32'(sel_err),    32'd0);
        check({tag, " stale"},      32'(stale),      32'd1);
    endtask

    // Monitor: every frame_done must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame: unexpected frame_done, digits=%h, expected none", digits);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (digits !== mon_exp) begin
                        fails++;
                        $display("FAIL frame: digits=%h, expected %h", digits, mon_exp);
                    end
                end
            end
            if (seg_err) seg_cnt++;
            if (sel_err) sel_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        wei  = 4'hF;
        duan = 8'hFF;
        #5 rst = 1'b1;
        #1 check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(4'hF, 8'hFF, 2);

        // "1234" scan
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h4321);
        check("scan digits", 32'(digits), 32'h4321);
        check("scan stale",  32'(stale),  32'd0);
        hold(4'hF, 8'hFF, 4);

        // Ghost: 3 samples must not capture slot 0; the frame only completes on a 4-sample hold
        hold(4'hE, 8'hC0, 3);
        hold(4'hF, 8'hFF, 4);
        hold(4'hD, 8'h92, 8);
        hold(4'hB, 8'h82, 8);
        hold(4'h7, 8'hF8, 8);
        exp_q.push_back(16'h7650);
        hold(4'hE, 8'hC0, 4);
        hold(4'hF, 8'hFF, 4);
        check("ghost frame consumed", 32'(exp_q.size()), 32'd0);

        // Bad pattern on digit 2
        s_seg = seg_cnt;
        hold(4'hB, 8'hFE, 8);
        check("bad pattern seg_err count", 32'(seg_cnt - s_seg), 32'd1);
        hold(4'hF, 8'hFF, 2);
        hold(4'hE, 8'h80, 8);
        hold(4'hD, 8'h90, 8);
        exp_q.push_back(16'hFE98);
        hold(4'h7, 8'hFF, 8);
        check("blank no seg_err", 32'(seg_cnt - s_seg), 32'd1);
        hold(4'hF, 8'hFF, 4);

        // Multi select
        s_sel = sel_cnt;
        s_seg = seg_cnt;
        hold(4'hC, 8'hC0, 20);
        hold(4'hF, 8'hFF, 4);
        check("multi sel_err count", 32'(sel_cnt - s_sel), 32'd1);
        check("multi no seg_err",    32'(seg_cnt - s_seg), 32'd0);
        check("multi digits held",   32'(digits),          32'hFE98);

        // Stale: last capture edge, 4 hold edges, then idle
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h4321);
        hold(4'hF, 8'hFF, 95);
        check("stale at 99", 32'(stale), 32'd0);
        hold(4'hF, 8'hFF, 1);
        check("stale at 100",       32'(stale),  32'd1);
        check("stale digits held",  32'(digits), 32'h4321);
        hold(4'hE, 8'hC0, 4);
        check("stale cleared by capture", 32'(stale), 32'd0);
        hold(4'hF, 8'hFF, 4);

        // Reset while digit 3 is on its third settling sample
        hold(4'hE, 8'hF9, 8);
        hold(4'hD, 8'hA4, 8);
        hold(4'hB, 8'hB0, 8);
        hold(4'h7, 8'h99, 3);
        s_seg = seg_cnt;
        s_sel = sel_cnt;
        rst = 1'b1;
        #1 check_reset_vals("mid reset");
        wei = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hold(4'hF, 8'hFF, 4);
        check("post reset digits",  32'(digits),          32'hFFFF);
        check("post reset seg_err", 32'(seg_cnt - s_seg), 32'd0);
        check("post reset sel_err", 32'(sel_cnt - s_sel), 32'd0);
        scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h4321);
        check("post reset scan digits", 32'(digits), 32'h4321);
        check("post reset scan stale",  32'(stale),  32'd0);
        hold(4'hF, 8'hFF, 2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
